// File: rtl/wb_pkg.sv
// Shared definitions for the writeback skid stage: load-type encoding,
// byte-offset width helper and raw load-type decode.
package wb_pkg;

   typedef enum logic [2:0] {
      LT_NONE = 3'd0,
      LT_LB   = 3'd1,
      LT_LH   = 3'd2,
      LT_LW   = 3'd3,
      LT_LBU  = 3'd4,
      LT_LHU  = 3'd5,
      LT_LD   = 3'd6,
      LT_ALU  = 3'd7
   } load_type_e;

   function automatic int off_w(input int xlen);
      return $clog2(xlen / 8);
   endfunction

   // A doubleword load only exists on a 64-bit datapath; elsewhere it writes nothing.
   function automatic load_type_e decode_load_type(input logic [2:0] raw, input int xlen);
      load_type_e lt;
      lt = load_type_e'(raw);
      if (lt == LT_LD && xlen != 64) lt = LT_NONE;
      return lt;
   endfunction

endpackage

// File: rtl/wb_stage_skid_if.sv
// Handshake and data bundle between the memory stage, the writeback skid
// stage and the register file.
interface wb_stage_skid_if #(
   parameter int XLEN = 32,
   parameter int RD_W = 5
);
   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] alu_out_m;
   logic [XLEN-1:0] ram_data_m;
   logic [XLEN-1:0] result_m;
   logic [RD_W-1:0] rd_m;
   logic [2:0]      reg_write_m;
   logic            mem_to_reg_m;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] wdata_w;
   logic [RD_W-1:0] rd_w;
   logic            we_w;
   logic            misalign_w;

   modport slave (
      input  in_valid, alu_out_m, ram_data_m, result_m, rd_m, reg_write_m, mem_to_reg_m,
      input  out_ready,
      output in_ready, out_valid, wdata_w, rd_w, we_w, misalign_w
   );

   modport master (
      output in_valid, alu_out_m, ram_data_m, result_m, rd_m, reg_write_m, mem_to_reg_m,
      output out_ready,
      input  in_ready, out_valid, wdata_w, rd_w, we_w, misalign_w
   );
endinterface

// File: rtl/wb_load_align.sv
// Combinational load data alignment: picks the byte/half/word/double at the
// byte offset and sign- or zero-extends it, or passes the ALU result through.
module wb_load_align
   import wb_pkg::*;
#(
   parameter  int XLEN  = 32,
   localparam int OFF_W = off_w(XLEN)
) (
   input  logic [XLEN-1:0]  ram_data,
   input  logic [XLEN-1:0]  result,
   input  load_type_e       load_type,
   input  logic             mem_to_reg,
   input  logic [OFF_W-1:0] offset,
   output logic [XLEN-1:0]  wdata,
   output logic             misalign
);

   logic [XLEN-1:0] shifted;

   assign shifted = ram_data >> {offset, 3'b000};

   always_comb begin
      // NOTE: every output gets a default first so no path through the case infers a latch.
      wdata    = result;
      misalign = 1'b0;
      if (mem_to_reg) begin
         case (load_type)
            LT_LB:   wdata = XLEN'($signed(shifted[7:0]));
            LT_LH: begin
               wdata    = XLEN'($signed(shifted[15:0]));
               misalign = offset[0];
            end
            LT_LW: begin
               wdata    = XLEN'($signed(shifted[31:0]));
               misalign = |offset[1:0];
            end
            LT_LBU:  wdata = XLEN'(shifted[7:0]);
            LT_LHU: begin
               wdata    = XLEN'(shifted[15:0]);
               misalign = offset[0];
            end
            LT_LD: begin
               wdata    = shifted;
               misalign = |offset;
            end
            default: wdata = ram_data;
         endcase
      end
   end

endmodule

// File: rtl/wb_stage_skid.sv
// Writeback stage with a two-entry (main + skid) buffer and a registered in_ready.
// Optional alignment checking is enabled by defining WB_MISALIGN_CHK_EN.
module wb_stage_skid
   import wb_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int RD_W = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   wb_stage_skid_if.slave        bus
);

   localparam int OFF_W = off_w(XLEN);

   typedef struct packed {
      logic [XLEN-1:0]  ram_data;
      logic [XLEN-1:0]  result;
      logic [RD_W-1:0]  rd;
      load_type_e       load_type;
      logic             mem_to_reg;
      logic [OFF_W-1:0] offset;
   } entry_t;

   entry_t main_q, main_d, skid_q, skid_d, in_entry;
   logic   main_valid_q, main_valid_d;
   logic   skid_valid_q, skid_valid_d;
   logic   in_ready_q, in_ready_d;
   logic   up_fire, dn_fire;
   logic   mis_raw;

   // Only the byte offset of the address is kept per entry.
   logic [XLEN-OFF_W-1:0] unused_alu_hi;
   assign unused_alu_hi = bus.alu_out_m[XLEN-1:OFF_W];

   assign up_fire = bus.in_valid && in_ready_q;
   assign dn_fire = main_valid_q && bus.out_ready;

   always_comb begin
      in_entry.ram_data   = bus.ram_data_m;
      in_entry.result     = bus.result_m;
      in_entry.rd         = bus.rd_m;
      in_entry.load_type  = decode_load_type(bus.reg_write_m, XLEN);
      in_entry.mem_to_reg = bus.mem_to_reg_m;
      in_entry.offset     = bus.alu_out_m[OFF_W-1:0];
   end

   always_comb begin
      main_d       = main_q;
      skid_d       = skid_q;
      main_valid_d = main_valid_q;
      skid_valid_d = skid_valid_q;
      if (clear) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (!main_valid_q || dn_fire) begin
         if (skid_valid_q) begin
            main_d       = skid_q;
            main_valid_d = 1'b1;
            skid_valid_d = up_fire;
            if (up_fire) skid_d = in_entry;
         end else begin
            main_valid_d = up_fire;
            if (up_fire) main_d = in_entry;
         end
      end else if (up_fire) begin
         skid_d       = in_entry;
         skid_valid_d = 1'b1;
      end
      in_ready_d = !skid_valid_d;
   end

   // NOTE: non-blocking assignments here so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_q       <= '0;
         skid_q       <= '0;
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         in_ready_q   <= 1'b0;
      end else begin
         main_q       <= main_d;
         skid_q       <= skid_d;
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
         in_ready_q   <= in_ready_d;
      end
   end

   wb_load_align #(.XLEN(XLEN)) u_align (
      .ram_data   (main_q.ram_data),
      .result     (main_q.result),
      .load_type  (main_q.load_type),
      .mem_to_reg (main_q.mem_to_reg),
      .offset     (main_q.offset),
      .wdata      (bus.wdata_w),
      .misalign   (mis_raw)
   );

`ifdef WB_MISALIGN_CHK_EN
   assign bus.misalign_w = main_valid_q && mis_raw;
`else
   logic unused_mis;
   assign unused_mis     = mis_raw;
   assign bus.misalign_w = 1'b0;
`endif

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = main_valid_q;
   assign bus.rd_w      = main_q.rd;
   assign bus.we_w      = main_valid_q && (main_q.load_type != LT_NONE)
                          && (main_q.rd != '0) && !bus.misalign_w;

endmodule

// File: tb/tb_wb_stage_skid.sv
// Self-checking bench for wb_stage_skid: directed vector table, multi-cycle
// corner sequences and randomized traffic against a queue-based model.
module tb_wb_stage_skid;
   import wb_pkg::*;

   localparam int XLEN  = 32;
   localparam int RD_W  = 5;
   localparam int OFF_W = off_w(XLEN);
`ifdef WB_MISALIGN_CHK_EN
   localparam bit MIS_EN = 1'b1;
`else
   localparam bit MIS_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   logic clear;

   always #5 clk = ~clk;

   wb_stage_skid_if #(.XLEN(XLEN), .RD_W(RD_W)) bus ();

   wb_stage_skid #(.XLEN(XLEN), .RD_W(RD_W)) dut (
      .clk   (clk),
      .rst   (rst),
      .clear (clear),
      .bus   (bus)
   );

   typedef struct {
      logic [XLEN-1:0] ram;
      logic [XLEN-1:0] res;
      logic [RD_W-1:0] rd;
      int              lt;
      bit              m2r;
      int              off;
   } ref_t;

   typedef struct {
      string       name;
      logic [2:0]  lt;
      logic        m2r;
      int          off;
      logic [31:0] ram;
      logic [31:0] res;
      logic [4:0]  rd;
      logic [31:0] exp_wd;
      logic        exp_we;
      logic        exp_mis;
      bit          chk_wd;
   } vec_t;

   ref_t mq[$];
   bit   m_in_ready;
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic ref_t cur_in();
      ref_t e;
      e.ram = bus.ram_data_m;
      e.res = bus.result_m;
      e.rd  = bus.rd_m;
      e.lt  = int'(bus.reg_write_m);
      if (e.lt == 6 && XLEN != 64) e.lt = 0;
      e.m2r = bus.mem_to_reg_m;
      e.off = int'(bus.alu_out_m % (XLEN / 8));
      return e;
   endfunction

   function automatic bit ref_mis(input ref_t e);
      if (!e.m2r) return 1'b0;
      if ((e.lt == 2 || e.lt == 5) && (e.off % 2) != 0) return 1'b1;
      if (e.lt == 3 && (e.off % 4) != 0) return 1'b1;
      if (e.lt == 6 && e.off != 0) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [XLEN-1:0] ref_wdata(input ref_t e);
      logic [63:0] sh, v;
      sh = 64'(e.ram) >> (8 * e.off);
      v  = 64'(e.res);
      if (e.m2r) begin
         case (e.lt)
            1: begin v = sh & 64'hFF;        if (v >= 64'h80)       v = v - 64'h100; end
            2: begin v = sh & 64'hFFFF;      if (v >= 64'h8000)     v = v - 64'h1_0000; end
            3: begin v = sh & 64'hFFFF_FFFF; if (v >= 64'h8000_0000) v = v - 64'h1_0000_0000; end
            4: v = sh & 64'hFF;
            5: v = sh & 64'hFFFF;
            6: v = sh;
            default: v = 64'(e.ram);
         endcase
      end
      return XLEN'(v);
   endfunction

   task automatic check_all(input string tag);
      check({tag, "_in_ready"}, bus.in_ready, m_in_ready);
      check({tag, "_out_valid"}, bus.out_valid, mq.size() > 0);
      if (mq.size() > 0) begin
         ref_t h;
         bit   mis, we, wd_ok;
         h     = mq[0];
         mis   = MIS_EN && ref_mis(h);
         we    = (h.lt != 0) && (h.rd != 0) && !mis;
         wd_ok = !(h.m2r && (h.lt == 0 || h.lt == 7)) && !mis;
         check({tag, "_rd_w"}, bus.rd_w, h.rd);
         check({tag, "_we_w"}, bus.we_w, we);
         check({tag, "_misalign_w"}, bus.misalign_w, mis);
         if (wd_ok) check({tag, "_wdata_w"}, bus.wdata_w, ref_wdata(h));
      end else begin
         check({tag, "_idle_we_w"}, bus.we_w, 1'b0);
         check({tag, "_idle_misalign_w"}, bus.misalign_w, 1'b0);
      end
   endtask

   // One clock: advance the model on the rising edge, compare on the falling edge.
   task automatic tick(input string tag);
      bit pop_ok, push_ok;
      @(posedge clk);
      if (rst || clear) begin
         mq.delete();
      end else begin
         pop_ok  = (mq.size() > 0) && bus.out_ready;
         push_ok = bus.in_valid && m_in_ready;
         if (pop_ok) void'(mq.pop_front());
         if (push_ok) mq.push_back(cur_in());
      end
      m_in_ready = !rst && (mq.size() < 2);
      @(negedge clk);
      check_all(tag);
   endtask

   task automatic drive_in(input bit v, input logic [2:0] lt, input logic m2r, input int off,
                           input logic [XLEN-1:0] ram, input logic [XLEN-1:0] res,
                           input logic [RD_W-1:0] rd);
      logic [XLEN-1:0] a;
      a = XLEN'($urandom);
      a[OFF_W-1:0] = OFF_W'(off);
      bus.in_valid     = v;
      bus.reg_write_m  = lt;
      bus.mem_to_reg_m = m2r;
      bus.alu_out_m    = a;
      bus.ram_data_m   = ram;
      bus.result_m     = res;
      bus.rd_m         = rd;
   endtask

   vec_t       vecs[10];
   logic [4:0] got[$];

   initial begin
      vecs[0] = '{"lb_off3",   3'd1, 1'b1, 3, 32'h80FF_1234, 32'h0,         5'd5,  32'hFFFF_FF80, 1'b1, 1'b0, 1'b1};
      vecs[1] = '{"lhu_off2",  3'd5, 1'b1, 2, 32'h8001_0000, 32'h0,         5'd6,  32'h0000_8001, 1'b1, 1'b0, 1'b1};
      vecs[2] = '{"alu_rd0",   3'd7, 1'b0, 0, 32'h5555_5555, 32'h0000_1234, 5'd0,  32'h0000_1234, 1'b0, 1'b0, 1'b1};
      vecs[3] = '{"lh_off2",   3'd2, 1'b1, 2, 32'h8001_0000, 32'h0,         5'd4,  32'hFFFF_8001, 1'b1, 1'b0, 1'b1};
      vecs[4] = '{"lbu_off1",  3'd4, 1'b1, 1, 32'h0000_F000, 32'h0,         5'd10, 32'h0000_00F0, 1'b1, 1'b0, 1'b1};
      vecs[5] = '{"lw_off0",   3'd3, 1'b1, 0, 32'hDEAD_BEEF, 32'h0,         5'd11, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1};
      vecs[6] = '{"ld_x32",    3'd6, 1'b1, 0, 32'h1234_5678, 32'h0,         5'd9,  32'h0,         1'b0, 1'b0, 1'b0};
      vecs[7] = '{"lw_off1",   3'd3, 1'b1, 1, 32'h1122_3344, 32'h0,         5'd7,  32'h0011_2233, !MIS_EN, MIS_EN, !MIS_EN};
      vecs[8] = '{"lh_off1",   3'd2, 1'b1, 1, 32'hAABB_CCDD, 32'h0,         5'd8,  32'hFFFF_BBCC, !MIS_EN, MIS_EN, !MIS_EN};
      vecs[9] = '{"alu_rd31",  3'd7, 1'b0, 2, 32'h0,         32'hCAFE_F00D, 5'd31, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b1};

      rst = 1'b1;
      clear = 1'b0;
      bus.out_ready = 1'b0;
      drive_in(1'b1, 3'd3, 1'b1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
      m_in_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_in_ready", bus.in_ready, 1'b0);
      check("rst_we_w", bus.we_w, 1'b0);
      check("rst_misalign_w", bus.misalign_w, 1'b0);
      check("rst_wdata_w", bus.wdata_w, '0);
      check("rst_rd_w", bus.rd_w, '0);
      bus.in_valid = 1'b0;
      rst = 1'b0;
      tick("post_rst");

      // Directed single transfers with hand-computed results.
      bus.out_ready = 1'b1;
      foreach (vecs[i]) begin
         drive_in(1'b1, vecs[i].lt, vecs[i].m2r, vecs[i].off, vecs[i].ram, vecs[i].res, vecs[i].rd);
         tick(vecs[i].name);
         check({vecs[i].name, "_tbl_out_valid"}, bus.out_valid, 1'b1);
         check({vecs[i].name, "_tbl_rd_w"}, bus.rd_w, vecs[i].rd);
         check({vecs[i].name, "_tbl_we_w"}, bus.we_w, vecs[i].exp_we);
         check({vecs[i].name, "_tbl_misalign_w"}, bus.misalign_w, vecs[i].exp_mis);
         if (vecs[i].chk_wd) check({vecs[i].name, "_tbl_wdata_w"}, bus.wdata_w, vecs[i].exp_wd);
         bus.in_valid = 1'b0;
         tick({vecs[i].name, "_drain"});
      end

      // Backpressure: two entries fill, third waits, then A,B,C drain in order.
      bus.out_ready = 1'b0;
      drive_in(1'b1, 3'd7, 1'b0, 0, 32'h0, 32'hA, 5'd1);
      tick("bp_a");
      check("bp_in_ready_after_a", bus.in_ready, 1'b1);
      drive_in(1'b1, 3'd7, 1'b0, 0, 32'h0, 32'hB, 5'd2);
      tick("bp_b");
      check("bp_in_ready_after_b", bus.in_ready, 1'b0);
      drive_in(1'b1, 3'd7, 1'b0, 0, 32'h0, 32'hC, 5'd3);
      tick("bp_c_wait");
      check("bp_in_ready_c_wait", bus.in_ready, 1'b0);
      check("bp_head_is_a", bus.rd_w, 5'd1);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         bit acc;
         if (bus.out_valid) got.push_back(bus.rd_w);
         acc = bus.in_valid && bus.in_ready;
         tick("bp_drain");
         if (acc) bus.in_valid = 1'b0;
      end
      check("bp_count", got.size(), 3);
      for (int i = 0; i < 3; i++) begin
         if (i < got.size()) check($sformatf("bp_order_%0d", i), got[i], 5'(i + 1));
      end

      // Clear with both entries full and a same-cycle offer on each side.
      bus.out_ready = 1'b0;
      drive_in(1'b1, 3'd7, 1'b0, 0, 32'h0, 32'hD, 5'd4);
      tick("clr_d");
      drive_in(1'b1, 3'd7, 1'b0, 0, 32'h0, 32'hE, 5'd5);
      tick("clr_e");
      check("clr_full_in_ready", bus.in_ready, 1'b0);
      clear = 1'b1;
      bus.out_ready = 1'b1;
      drive_in(1'b1, 3'd7, 1'b0, 0, 32'h0, 32'hF, 5'd6);
      tick("clr_edge");
      check("clr_out_valid", bus.out_valid, 1'b0);
      check("clr_in_ready", bus.in_ready, 1'b1);
      clear = 1'b0;
      bus.in_valid = 1'b0;
      tick("clr_after");
      check("clr_nothing_captured", bus.out_valid, 1'b0);

      // Reset while both entries are held discards them immediately.
      bus.out_ready = 1'b0;
      drive_in(1'b1, 3'd1, 1'b1, 0, 32'h7F, 32'h0, 5'd12);
      tick("mr_a");
      tick("mr_b");
      bus.in_valid = 1'b0;
      rst = 1'b1;
      #1;
      mq.delete();
      m_in_ready = 1'b0;
      check("mr_out_valid", bus.out_valid, 1'b0);
      check("mr_in_ready", bus.in_ready, 1'b0);
      check("mr_we_w", bus.we_w, 1'b0);
      check("mr_wdata_w", bus.wdata_w, '0);
      @(negedge clk);
      rst = 1'b0;
      tick("mr_release");

      // Randomized traffic with occasional flushes.
      for (int i = 0; i < 600; i++) begin
         logic [2:0] lt;
         lt = 3'($urandom_range(0, 7));
         drive_in($urandom_range(0, 3) != 0, lt, (lt >= 3'd1 && lt <= 3'd6),
                  int'($urandom_range(0, 3)), XLEN'($urandom), XLEN'($urandom),
                  ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)));
         bus.out_ready = ($urandom_range(0, 2) != 0);
         clear = ($urandom_range(0, 24) == 0);
         tick("rnd");
      end
      clear = 1'b0;
      bus.in_valid = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
